// File: rtl/apb_rr_arbiter_if.sv
// Client command/response handshake plus apb_master command and bus-tap signals
// for apb_rr_arbiter. The slave modport is the arbiter side.
interface apb_rr_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_rw;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   m_transfer;
  logic                   m_rw;
  logic [ADDR_W-1:0]      m_rd_addr;
  logic [ADDR_W-1:0]      m_wr_addr;
  logic [DATA_W-1:0]      m_wr_val;
  logic                   psel;
  logic                   penable;
  logic                   pready;
  logic [DATA_W-1:0]      prdata;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, psel, penable, pready, prdata,
    output req_ready, rsp_valid, rsp_rdata, m_transfer, m_rw, m_rd_addr, m_wr_addr, m_wr_val
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, psel, penable, pready, prdata,
    input  req_ready, rsp_valid, rsp_rdata, m_transfer, m_rw, m_rd_addr, m_wr_addr, m_wr_val
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Four-way round-robin front end for a single apb_master: one command in flight,
// completion detected by monitoring psel & penable & pready on the bus.
module apb_rr_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              pclk,
  input  logic              preset,
  apb_rr_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic [1:0]        ptr, gnt_id, win, idx;
  logic              found, hs, complete;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  // Scan downward so the requester closest to ptr is the last match and wins.
  always_comb begin
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (bus.req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign hs       = (state == S_IDLE) && found && !preset;
  assign complete = (state == S_WAIT) && bus.psel && bus.penable && bus.pready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (hs) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (complete) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (hs) bus.req_ready[win] = 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (preset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      ptr         <= '0;
      gnt_id      <= '0;
      cmd_rw      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (hs) begin
        cmd_rw    <= bus.req_rw[win];
        cmd_addr  <= bus.req_addr[win*ADDR_W +: ADDR_W];
        cmd_wdata <= bus.req_wdata[win*DATA_W +: DATA_W];
        gnt_id    <= win;
        ptr       <= win + 2'd1;
      end
      if (complete) begin
        rsp_valid_q[gnt_id] <= 1'b1;
        rsp_rdata_q         <= cmd_rw ? '0 : bus.prdata;
      end
    end
  end

  // Held from the command register so the master sees a stable command
  // across SETUP and every ACCESS wait state.
  assign bus.m_transfer = (state == S_ISSUE);
  assign bus.m_rw       = cmd_rw;
  assign bus.m_rd_addr  = cmd_addr;
  assign bus.m_wr_addr  = cmd_addr;
  assign bus.m_wr_val   = cmd_rw ? cmd_wdata : '0;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter with a small behavioural APB master/slave
// (configurable wait states) closing the loop on m_transfer.
module tb_apb_rr_arbiter;
  logic pclk = 1'b0;
  logic preset;
  int   n_cmp = 0;
  int   n_bad = 0;

  apb_rr_arbiter_if #(.NREQ(4), .ADDR_W(4), .DATA_W(16)) bus ();

  apb_rr_arbiter #(.NREQ(4), .ADDR_W(4), .DATA_W(16)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  // Behavioural master + slave: 0 idle, 1 setup, 2 access; pready on access cycle ws.
  logic [1:0]  mst;
  int          acc;
  int          ws;
  logic        stray;
  logic [15:0] slv_rdata;

  always @(posedge pclk) begin
    if (preset) begin
      mst <= 2'd0;
      acc <= 0;
    end else begin
      case (mst)
        2'd0: if (bus.m_transfer) mst <= 2'd1;
        2'd1: begin mst <= 2'd2; acc <= 0; end
        2'd2: if (bus.pready) mst <= bus.m_transfer ? 2'd1 : 2'd0;
              else acc <= acc + 1;
        default: mst <= 2'd0;
      endcase
    end
  end

  assign bus.psel    = (mst != 2'd0);
  assign bus.penable = (mst == 2'd2);
  assign bus.pready  = ((mst == 2'd2) && (acc == ws)) || stray;
  assign bus.prdata  = ((mst == 2'd2) && (acc == ws)) ? slv_rdata : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rw, input logic [3:0] a, input logic [15:0] d);
    bus.req_valid[i]         = 1'b1;
    bus.req_rw[i]            = rw;
    bus.req_addr[i*4 +: 4]   = a;
    bus.req_wdata[i*16 +: 16] = d;
  endtask

  task automatic clr_req(input int i);
    bus.req_valid[i] = 1'b0;
  endtask

  // Requesters i and j already valid with writes, zero wait states:
  // i wins now, j is handshaken in the cycle of i's response.
  task automatic pair(input int i, input int j);
    logic [3:0] oh_i, oh_j;
    oh_i = 4'b0001 << i;
    oh_j = 4'b0001 << j;
    #1;
    chk("pair_gnt_first", 32'(bus.req_ready), 32'(oh_i));
    tick; clr_req(i);
    repeat (3) tick;
    #1;
    chk("pair_rsp_first", 32'(bus.rsp_valid), 32'(oh_i));
    chk("pair_rdata_wr", 32'(bus.rsp_rdata), 32'h0);
    chk("pair_gnt_second", 32'(bus.req_ready), 32'(oh_j));
    tick; clr_req(j);
    repeat (3) tick;
    #1;
    chk("pair_rsp_second", 32'(bus.rsp_valid), 32'(oh_j));
  endtask

  initial begin
    preset        = 1'b1;
    bus.req_valid = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    ws            = 0;
    stray         = 1'b0;
    slv_rdata     = 16'h0;

    // Reset state, with r1 already requesting
    set_req(1, 1'b1, 4'h5, 16'hBEEF);
    tick; tick; #1;
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_transfer", 32'(bus.m_transfer), 32'h0);
    chk("rst_addr", 32'(bus.m_wr_addr), 32'h0);
    chk("rst_rdata", 32'(bus.rsp_rdata), 32'h0);

    // Single write r1 -> 0x5 = 0xBEEF, zero wait states
    tick; preset = 1'b0; #1;
    chk("wr_c0_ready", 32'(bus.req_ready), 32'b0010);
    tick; clr_req(1); #1;
    chk("wr_c1_transfer", 32'(bus.m_transfer), 32'h1);
    chk("wr_c1_ready", 32'(bus.req_ready), 32'h0);
    tick; #1;
    chk("wr_c2_transfer", 32'(bus.m_transfer), 32'h0);
    chk("wr_c2_psel", 32'(bus.psel), 32'h1);
    chk("wr_c2_addr", 32'(bus.m_wr_addr), 32'h5);
    chk("wr_c2_wval", 32'(bus.m_wr_val), 32'hBEEF);
    chk("wr_c2_rw", 32'(bus.m_rw), 32'h1);
    tick; #1;
    chk("wr_c3_addr", 32'(bus.m_wr_addr), 32'h5);
    chk("wr_c3_wval", 32'(bus.m_wr_val), 32'hBEEF);
    chk("wr_c3_rsp", 32'(bus.rsp_valid), 32'h0);
    tick; #1;
    chk("wr_c4_rsp", 32'(bus.rsp_valid), 32'b0010);
    chk("wr_c4_rdata", 32'(bus.rsp_rdata), 32'h0);
    tick; #1;
    chk("wr_c5_rsp_one_shot", 32'(bus.rsp_valid), 32'h0);

    // Read r2 @0xA, 3 wait states, stray pready outside ACCESS
    ws = 3; slv_rdata = 16'h1234;
    set_req(2, 1'b0, 4'hA, 16'h5555);
    #1;
    chk("rd_c0_ready", 32'(bus.req_ready), 32'b0100);
    for (int c = 1; c <= 6; c++) begin
      tick;
      if (c == 1) clr_req(2);
      stray = (c <= 2);
      #1;
      chk("rd_cmd_rw", 32'(bus.m_rw), 32'h0);
      chk("rd_cmd_rdaddr", 32'(bus.m_rd_addr), 32'hA);
      chk("rd_cmd_wval", 32'(bus.m_wr_val), 32'h0);
      chk("rd_no_early_rsp", 32'(bus.rsp_valid), 32'h0);
      chk("rd_transfer", 32'(bus.m_transfer), (c == 1) ? 32'h1 : 32'h0);
    end
    tick; stray = 1'b0; #1;
    chk("rd_c7_rsp", 32'(bus.rsp_valid), 32'b0100);
    chk("rd_c7_rdata", 32'(bus.rsp_rdata), 32'h1234);

    // Pointer wrap: r3 alone, then r0 and r2 together
    ws = 0;
    tick; set_req(3, 1'b1, 4'h3, 16'h3333);
    #1;
    chk("wrap_r3_ready", 32'(bus.req_ready), 32'b1000);
    tick; clr_req(3);
    repeat (3) tick;
    #1;
    chk("wrap_r3_rsp", 32'(bus.rsp_valid), 32'b1000);
    tick;
    set_req(0, 1'b1, 4'h1, 16'h0101);
    set_req(2, 1'b1, 4'h2, 16'h0202);
    pair(0, 2);

    // Reset during ACCESS: ptr is 3 here, r1 wins
    tick; ws = 2;
    set_req(1, 1'b0, 4'h7, 16'h0);
    #1;
    chk("mid_c0_ready", 32'(bus.req_ready), 32'b0010);
    tick; clr_req(1);
    tick;
    tick; preset = 1'b1; #1;
    chk("mid_in_access", 32'(bus.penable), 32'h1);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    tick; preset = 1'b0; #1;
    chk("mid_transfer", 32'(bus.m_transfer), 32'h0);
    for (int c = 0; c < 4; c++) begin
      chk("mid_no_rsp", 32'(bus.rsp_valid), 32'h0);
      tick;
    end
    ws = 0;
    // ptr back to 0: r0 must beat r3
    set_req(0, 1'b1, 4'h4, 16'h4444);
    set_req(3, 1'b1, 4'hC, 16'hCCCC);
    pair(0, 3);

    // Round robin: all four hold req_valid from reset
    tick; preset = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(i), 16'(i));
    tick; tick; preset = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      logic [3:0] exp_rdy, exp_rsp;
      if (k > 0) tick;
      #1;
      exp_rdy = (k % 4 == 0) ? (4'b0001 << ((k / 4) % 4)) : 4'b0000;
      exp_rsp = (k % 4 == 0 && k > 0) ? (4'b0001 << ((k / 4 - 1) % 4)) : 4'b0000;
      chk("rr_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("rr_rsp", 32'(bus.rsp_valid), 32'(exp_rsp));
    end
    bus.req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/apb_rr_arbiter.md
# apb_rr_arbiter

Four-requester round-robin front end that shares one `apb_master` command port among independent clients. It accepts read/write commands over per-requester valid/ready handshakes and latches the winning command. It pulses `transfer` into the master and holds the command stable while the master runs SETUP/ACCESS. It watches the APB bus for completion and returns a one-hot done pulse plus read data to the issuing requester.

## Interface
- `NREQ`, 4: number of requesters; fixed at 4, and the priority logic assumes 4.
- `ADDR_W`, 4: APB address width; matches `paddr`.
- `DATA_W`, 16: APB data width; matches `pwdata` and `prdata`.

Ports:
- `pclk`  in  1  single clock, shared with `apb_master`.
- `preset`  in  1  synchronous, active-high reset, sampled on the rising edge of `pclk`.
- `req_valid`  in  4  per-requester command valid; must be held, with its payload, until ready.
- `req_rw`  in  4  per-requester direction: 1 = write, 0 = read.
- `req_addr`  in  16  packed 4 x `ADDR_W`; requester i occupies `[4i+3:4i]`.
- `req_wdata`  in  64  packed 4 x `DATA_W`; requester i occupies `[16i+15:16i]`.
- `req_ready`  out  4  one-hot accept; combinational, asserted only in IDLE.
- `rsp_valid`  out  4  one-hot, one-cycle completion pulse to the issuing requester.
- `rsp_rdata`  out  16  read data; valid with `rsp_valid` on reads, 0 on writes.
- `m_transfer`  out  1  to `apb_master.transfer`.
- `m_rw`  out  1  to `apb_master.rw`.
- `m_rd_addr`  out  4  to `apb_master.rd_addr`.
- `m_wr_addr`  out  4  to `apb_master.wr_addr`.
- `m_wr_val`  out  16  to `apb_master.wr_val`.
- `psel`, `penable`, `pready`  in  1 each  bus monitor taps.
- `prdata`  in  16  bus monitor tap.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - Winner = first `req_valid[i]` found scanning from `ptr` upward, modulo 4.
  - `req_ready[winner]` = 1. Handshake completes at the edge.
  - On handshake: latch rw, addr and wdata into the command register and the requester index into `gnt_id`; set `ptr` = `gnt_id`+1 mod 4; go to ISSUE.
  - No valid requester: stay in IDLE, `ptr` unchanged.
- **ISSUE**
  - `m_transfer` = 1 for exactly one cycle; go to WAIT unconditionally.
  - The master is in IDLE here, so it always enters SETUP next.
- **WAIT**
  - `m_transfer` = 0, so the master returns to IDLE on completion rather than chaining a new SETUP.
  - Completion = `psel & penable & pready`.
  - On completion: capture `prdata` if the command is a read, else capture 0; set `rsp_valid[gnt_id]` for the next cycle; go to IDLE.
- Command outputs:
  - Driven from the command register, constant from ISSUE through the completion cycle.
  - `m_rd_addr` and `m_wr_addr` both carry the latched address.
  - `m_wr_val` = latched wdata on writes, 0 on reads.
- Only one transfer is outstanding at any time. Requesters that are not granted are never dropped; they wait with `req_valid` held.

## Timing
- Reset values: state IDLE; `ptr` = 0; `m_transfer` = 0; `rsp_valid` = 0; `rsp_rdata` = 0; command register = 0.
  - `req_ready` = 0 during any cycle `preset` = 1.
- `preset` must be driven together with the master's `presetn` (`presetn` = ~`preset`).
  - Reset mid-transfer abandons it with no `rsp_valid`; the requester must re-issue.
- Zero-wait-state schedule:
  - C0: IDLE handshake.
  - C1: ISSUE.
  - C2: master SETUP (`psel`=1).
  - C3: master ACCESS, `pready`=1, completion.
  - C4: `rsp_valid` pulse; arbiter back in IDLE and may handshake again in the same cycle.
- Latency: handshake to `rsp_valid` = 4 cycles + N wait states.
- Throughput: at most one transfer per 4 cycles.
- `pready` asserted without `psel & penable` is ignored.
- `rsp_valid` is never asserted for two consecutive cycles.

## Test plan
- Single write: r1 writes addr 0x5 with 0xBEEF, zero wait states.
  - `req_ready[1]` at C0; `m_transfer` high only in C1; `paddr`=0x5 and `pwdata`=0xBEEF in C2–C3; `rsp_valid`=4'b0010 at C4; `rsp_rdata`=0.
- Read with 3 wait states: r2 reads addr 0xA; the slave returns 0x1234 on the 4th ACCESS cycle.
  - `rsp_valid`=4'b0100 at C7 with `rsp_rdata`=0x1234; command outputs stable C1–C6.
- Round robin: all 4 requesters hold `req_valid` from reset.
  - Grant order is 0, 1, 2, 3, 0; each grant 4 cycles apart.
- Pointer wrap: after r3 is served, r0 and r2 request together.
  - r0 is granted first; r2 is granted next.
- Reset mid-WAIT: assert `preset` during ACCESS.
  - No `rsp_valid`; `m_transfer`=0; `ptr`=0.
  - A new r3 request after reset completes normally.
